// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings and default latencies, used by mdu_ctrl
// and by the decode controller.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div_op(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_long_op(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU bundle: E-stage issue, D-stage hazard query and HI/LO read-out.
interface mdu_ctrl_if;
  import mdu_pkg::*;

  // Handshake: an op is accepted on an edge where start=1, Req=0 and busy=0.
  // start while busy is dropped (not queued); the pipeline holds via stall_D.
  logic        Req;
  logic        start;
  md_op_t      mdOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        md_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Req, start, mdOp, srcA, srcB, md_D,
    input  busy, stall_D, HI, LO
  );

  modport slave (
    input  Req, start, mdOp, srcA, srcB, md_D,
    output busy, stall_D, HI, LO
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide core; result packed as {hi, lo}.
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic signed [63:0] a_sx, b_sx;
  logic        [63:0] a_zx, b_zx;
  logic signed [31:0] q_s, r_s;
  logic        [31:0] q_u, r_u;

  always_comb begin
    a_sx = {{32{a[31]}}, a};
    b_sx = {{32{b[31]}}, b};
    a_zx = {32'd0, a};
    b_zx = {32'd0, b};
    q_s  = '0;
    r_s  = '0;
    q_u  = '0;
    r_u  = '0;
    // Divide-by-zero yields 0 here; the controller never commits it anyway.
    if (b != 32'd0) begin
      q_u = a / b;
      r_u = a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q_s = {1'b1, 31'd0};
        r_s = '0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end
    result = '0;
    case (op)
      MD_MULT:  result = a_sx * b_sx;
      MD_MULTU: result = a_zx * b_zx;
      MD_DIV:   result = {r_s, q_s};
      MD_DIVU:  result = {r_u, q_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: fixed-latency mult/div with HI/LO commit. Optional macro
// MDU_DIVZERO_SKIP_EN turns divide-by-zero into a zero-cycle no-op.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic      clk,
  input logic      reset,
  mdu_ctrl_if.slave mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic [63:0]      pend;
  logic             pend_wr;
  logic [31:0]      hi_q, lo_q;
  logic [63:0]      arith_res;
  logic             busy_w, issue, div_zero, long_issue;

  mdu_arith u_arith (
    .op     (mdu.mdOp),
    .a      (mdu.srcA),
    .b      (mdu.srcB),
    .result (arith_res)
  );

  assign busy_w   = (cnt != '0);
  assign issue    = mdu.start && !mdu.Req && !busy_w;
  assign div_zero = is_div_op(mdu.mdOp) && (mdu.srcB == 32'd0);
  assign load_val = is_div_op(mdu.mdOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

`ifdef MDU_DIVZERO_SKIP_EN
  assign long_issue = issue && is_long_op(mdu.mdOp) && !div_zero;
`else
  assign long_issue = issue && is_long_op(mdu.mdOp);
`endif

  // A zero-divisor op still occupies the unit but its commit is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (busy_w) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1) && pend_wr) begin
        hi_q <= pend[63:32];
        lo_q <= pend[31:0];
      end
    end else if (long_issue) begin
      cnt     <= load_val;
      pend    <= arith_res;
      pend_wr <= !div_zero;
    end else if (issue && mdu.mdOp == MD_MTHI) begin
      hi_q <= mdu.srcA;
    end else if (issue && mdu.mdOp == MD_MTLO) begin
      lo_q <= mdu.srcA;
    end
  end

  assign mdu.busy    = busy_w;
  assign mdu.stall_D = mdu.md_D && (mdu.start || busy_w);
  assign mdu.HI      = hi_q;
  assign mdu.LO      = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases then random traffic
// against a cycle-indexed reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_DIVZERO_SKIP_EN
  localparam bit SKIP_DZ = 1'b1;
`else
  localparam bit SKIP_DZ = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];   // result awaiting commit
  bit          c_wr;
  bit          c_pend;
  longint      edge_n;
  longint      c_edge;

  function automatic logic [63:0] ref_op(md_op_t op, logic [31:0] a, logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 0) return 64'd0;
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return 64'd0;
        return {32'(ua - (ua / ub) * ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(bit s, md_op_t op, logic [31:0] a, logic [31:0] b, bit req, bit md);
    bus.start = s;
    bus.mdOp  = op;
    bus.srcA  = a;
    bus.srcB  = b;
    bus.Req   = req;
    bus.md_D  = md;
  endtask

  // One clock: check stall_D, advance the model across the edge, check state.
  task automatic tick();
    bit          iss;
    md_op_t      op;
    logic [31:0] a, b;
    logic [63:0] v;
    #1;
    chk("stall_D", {31'd0, bus.stall_D}, {31'd0, bus.md_D && (bus.start || c_pend)});
    iss = bus.start && !bus.Req && !c_pend && !reset;
    op  = bus.mdOp;
    a   = bus.srcA;
    b   = bus.srcB;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      exp_q.delete();
      c_pend = 1'b0;
    end else begin
      if (c_pend && edge_n == c_edge) begin
        v = exp_q.pop_front();
        if (c_wr) begin
          m_hi = v[63:32];
          m_lo = v[31:0];
        end
        c_pend = 1'b0;
      end
      if (iss) begin
        case (op)
          MD_MTHI: m_hi = a;
          MD_MTLO: m_lo = a;
          MD_MULT, MD_MULTU: begin
            exp_q.push_back(ref_op(op, a, b));
            c_wr = 1'b1; c_pend = 1'b1; c_edge = edge_n + MC;
          end
          MD_DIV, MD_DIVU: begin
            if (b != 0 || !SKIP_DZ) begin
              exp_q.push_back(ref_op(op, a, b));
              c_wr = (b != 0); c_pend = 1'b1; c_edge = edge_n + DC;
            end
          end
          default: ;
        endcase
      end
    end
    #1;
    chk("busy", {31'd0, bus.busy}, {31'd0, c_pend});
    chk("HI", bus.HI, m_hi);
    chk("LO", bus.LO, m_lo);
  endtask

  task automatic issue_op(md_op_t op, logic [31:0] a, logic [31:0] b, bit req, bit md);
    drive(1'b1, op, a, b, req, md);
    tick();
    drive(1'b0, op, a, b, 1'b0, md);
  endtask

  task automatic run_idle(output int n);
    n = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      n++;
      tick();
    end
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    edge_n = 0; c_edge = 0; c_pend = 1'b0; c_wr = 1'b0;
    m_hi = '0; m_lo = '0;
    reset = 1'b1;
    drive(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_HI", bus.HI, 32'd0);
    chk("rst_LO", bus.LO, 32'd0);

    // MULT signed with md_D held high: stall through the last busy cycle
    issue_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    run_idle(n);
    chk("mult_cycles", n, MC);
    chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bus.LO, 32'hFFFF_FFFE);
    #1 chk("stall_after", {31'd0, bus.stall_D}, 32'd0);

    // DIV / DIVU of -7 by 2, md_D low: no stall at any point
    issue_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_idle(n);
    chk("div_cycles", n, DC);
    chk("div_LO", bus.LO, 32'hFFFF_FFFD);
    chk("div_HI", bus.HI, 32'hFFFF_FFFF);
    issue_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_idle(n);
    chk("divu_cycles", n, DC);
    chk("divu_LO", bus.LO, 32'h7FFF_FFFC);
    chk("divu_HI", bus.HI, 32'd1);

    // MULTU cancelled by a same-cycle Req
    issue_op(MD_MULTU, 32'd3, 32'd4, 1'b1, 1'b0);
    chk("req_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("req_HI", bus.HI, 32'd1);
    chk("req_LO", bus.LO, 32'h7FFF_FFFC);

    // MTHI/MTLO take effect at the issue edge
    issue_op(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    chk("mthi_HI", bus.HI, 32'h0000_1234);
    issue_op(MD_MTLO, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
    chk("mtlo_LO", bus.LO, 32'h0000_5678);

    // Divide by zero
    issue_op(MD_DIV, 32'd99, 32'd0, 1'b0, 1'b0);
    run_idle(n);
    chk("dz_cycles", n, SKIP_DZ ? 0 : DC);
    chk("dz_HI", bus.HI, 32'h0000_1234);
    chk("dz_LO", bus.LO, 32'h0000_5678);

    // Reset in busy cycle 3 of a DIV aborts it
    issue_op(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_HI", bus.HI, 32'd0);
    chk("abort_LO", bus.LO, 32'd0);
    repeat (15) tick();
    chk("abort_late_HI", bus.HI, 32'd0);
    chk("abort_late_LO", bus.LO, 32'd0);

    // Random traffic: start during busy, Req, zero divisors, occasional reset
    for (int i = 0; i < 800; i++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      drive($urandom_range(0, 2) != 0, md_op_t'($urandom_range(0, 5)), $urandom(), rb,
            $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    drive(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
    run_idle(n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  in  1  single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Req  in  1  exception/interrupt request from the pipeline; cancels same-cycle issue.
REQ-006 SHALL have port start  in  1  E-stage holds a valid MDU op this cycle.
REQ-007 SHALL have port mdOp  in  3  op code from shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 SHALL have port srcA  in  32  forwarded rs value.
REQ-009 SHALL have port srcB  in  32  forwarded rt value.
REQ-010 SHALL have port md_D  in  1  D-stage instr uses the MDU (mult/div/mthi/mtlo/mfhi/mflo).
REQ-011 SHALL have port busy  out  1  multi-cycle op in flight.
REQ-012 SHALL have port stall_D  out  1  stall request to the hazard unit.
REQ-013 SHALL have port HI  out  32  architectural HI.
REQ-014 SHALL have port LO  out  32  architectural LO.

Function
REQ-015 SHALL define issue = start && !Req && !busy; start while busy is ignored.
REQ-016 SHALL, on issue of MULT/MULTU/DIV/DIVU at edge t, latch the result into a pending register and load a down-counter with MULT_CYCLES or DIV_CYCLES.
REQ-017 SHALL drive busy = (counter != 0); busy is high in cycles t+1 .. t+N.
REQ-018 SHALL decrement the counter by 1 each cycle while nonzero, and commit the pending result to HI/LO on the edge where the counter goes 1->0; new HI/LO are visible from cycle t+N+1.
REQ-019 SHALL compute MULT as a signed 64-bit product and MULTU as unsigned, with HI = [63:32] and LO = [31:0].
REQ-020 SHALL compute DIV/DIVU with LO = quotient and HI = remainder; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 SHALL, on issue of MTHI/MTLO, write srcA to HI/LO at that edge with no busy cycles.
REQ-022 SHALL drive HI/LO combinationally from their architectural registers; MFHI/MFLO read them directly.
REQ-023 SHALL drive stall_D = md_D && (start || busy).
REQ-024 SHALL cancel the op when Req is asserted in the same cycle as start: no counter load and no HI/LO write.
REQ-025 SHALL let Req asserted while busy leave the in-flight op running to completion.
REQ-026 SHALL, for DIV/DIVU with srcB = 0 (without the macro), run DIV_CYCLES busy cycles and then leave HI/LO unchanged.

Reset
REQ-027 SHALL, on reset, set HI = 0, LO = 0, counter = 0 (busy = 0) and pending = 0, aborting any in-flight op.
REQ-028 SHALL give reset priority over issue and over commit in the same cycle.

Configuration
REQ-029 SHALL, when MDU_DIVZERO_SKIP_EN is defined, treat DIV/DIVU with srcB = 0 as a no-op: no busy cycles, HI/LO unchanged, stall_D depends on start only.
REQ-030 SHALL, when MDU_DIVZERO_SKIP_EN is undefined, behave per REQ-026.

Structure
REQ-031 SHALL place the mdOp encodings and the default MULT_CYCLES/DIV_CYCLES constants in the shared mdu_pkg package/header, included by both mdu_ctrl and the decode Controller.
REQ-032 SHALL isolate the multiply/divide arithmetic in one combinational sub-module, mdu_arith, with a 64-bit {hi,lo} output.

Verification
REQ-033 SHALL cover: MULT srcA=0xFFFFFFFF, srcB=2 -> busy for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE.
REQ-034 SHALL cover: DIV srcA=-7, srcB=2 -> busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU of the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-035 SHALL cover: MULTU issued with Req=1 in the same cycle -> busy stays 0 and HI/LO are unchanged.
REQ-036 SHALL cover: md_D=1 during busy -> stall_D=1 through the last busy cycle, then 0; md_D=0 -> stall_D=0 throughout.
REQ-037 SHALL cover: reset asserted at busy cycle 3 of a DIV -> next cycle busy=0, HI=0, LO=0, and no later commit.
REQ-038 SHALL cover: DIV with srcB=0 -> with MDU_DIVZERO_SKIP_EN, busy never rises; without it, 10 busy cycles; HI/LO unchanged in both cases.
